// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
// Holds the access-size and FSM-state encodings and the alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR
  } lsu_state_e;

  // True for any request that must be rejected: a misaligned half or word,
  // or the reserved size encoding.
  function automatic logic misaligned(input size_e size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic between a memory word and the CPU-side data.
// Extracts and extends loads; merges sub-word store data into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    case (lane)
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase
    hsel = lane[1] ? rword[31:16] : rword[15:0];

    case (size)
      SZ_BYTE: rdata = {{24{~uns & bsel[7]}}, bsel};
      SZ_HALF: rdata = {{16{~uns & hsel[15]}}, hsel};
      default: rdata = rword;
    endcase

    merged = rword;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte/half/word access per request against a
// word-addressed memory with combinational read and synchronous write.
//
// state  | meaning
// IDLE   | ready for a request; rejected requests complete from here
// LOAD   | memory read, extracted data registered at the end of the cycle
// STORE  | full-word write
// RMW_RD | read containing word, merge sub-word store data
// RMW_WR | write merged word
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              iClk,
  input  logic              iResetN,
  input  logic              iReq,
  output logic              oReady,
  input  logic              iWe,
  input  logic [1:0]        iSize,
  input  logic              iUnsigned,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWdata,
  output logic              oValid,
  output logic [31:0]       oRdata,
  output logic              oErr,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWdata,
  input  logic [31:0]       iMemRdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       ld_data;
  logic [31:0]       merged;

  lsu_align u_align (
    .rword  (iMemRdata),
    .wdata  (wdata_q),
    .size   (size_q),
    .lane   (addr_q[1:0]),
    .uns    (uns_q),
    .rdata  (ld_data),
    .merged (merged)
  );

  // Derived from state so it reads 1 the moment reset clears the state.
  assign oReady = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (iReq) begin
          we_d    = iWe;
          size_d  = size_e'(iSize);
          uns_d   = iUnsigned;
          addr_d  = iAddr;
          wdata_d = iWdata;
          if (misaligned(size_e'(iSize), iAddr[1:0])) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            mem_addr_d = {iAddr[ADDR_W-1:2], 2'b00};
            if (!iWe) begin
              state_d = LOAD;
            end else if (size_e'(iSize) == SZ_WORD) begin
              state_d     = STORE;
              mem_we_d    = 1'b1;
              mem_wdata_d = iWdata;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      LOAD: begin
        rdata_d    = ld_data;
        valid_d    = 1'b1;
        mem_addr_d = '0;
        state_d    = IDLE;
      end
      RMW_RD: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = merged;
        state_d     = RMW_WR;
      end
      STORE, RMW_WR: begin
        rdata_d    = '0;
        valid_d    = 1'b1;
        mem_addr_d = '0;
        state_d    = IDLE;
      end
      default: begin
        mem_addr_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign oValid    = valid_q;
  assign oErr      = err_q;
  assign oRdata    = rdata_q;
  assign oMemWe    = mem_we_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWdata = mem_wdata_q;

endmodule
